// File: rtl/tick_bcd_counter_if.sv
// Bundle of the tick counter's control inputs and its digit/display outputs.
// master drives the controls and observes the outputs; slave is the counter itself.
interface tick_bcd_counter_if;
    logic       tick_in;
    logic       en;
    logic       up_dn;
    logic       clr;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic       wrap;
    logic [6:0] seg;
    logic [1:0] an;

    modport master (
        output tick_in, en, up_dn, clr,
        input  bcd_tens, bcd_ones, wrap, seg, an
    );

    modport slave (
        input  tick_in, en, up_dn, clr,
        output bcd_tens, bcd_ones, wrap, seg, an
    );
endinterface

// File: rtl/tick_bcd_counter.sv
// Two-digit BCD up/down counter stepped by rising edges of an asynchronous divider tick,
// with a time-multiplexed seven-segment display driver.
module tick_bcd_counter #(
    parameter int MAX_COUNT      = 59,
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    tick_bcd_counter_if.slave   bus
);
    localparam logic [3:0] MAX_TENS = 4'(MAX_COUNT / 10);
    localparam logic [3:0] MAX_ONES = 4'(MAX_COUNT % 10);
    localparam int SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    logic              r_s1, r_s2, r_s3;
    logic [3:0]        r_tens, r_ones;
    logic              r_wrap;
    logic [SCAN_W-1:0] r_scan_cnt;
    logic              r_dig_sel;

    logic              w_step;
    logic              w_at_max, w_at_zero;
    logic [3:0]        w_digit;
    logic [6:0]        w_seg_hi;
    logic [1:0]        w_an_hi;

    // Sync flops reset high so a tick already high at reset release is not seen as an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
            r_s3 <= 1'b1;
        end else begin
            r_s1 <= bus.tick_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_step    = r_s2 & ~r_s3;
    assign w_at_max  = (r_tens == MAX_TENS) && (r_ones == MAX_ONES);
    assign w_at_zero = (r_tens == 4'd0) && (r_ones == 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tens <= 4'd0;
            r_ones <= 4'd0;
            r_wrap <= 1'b0;
        end else if (bus.clr) begin
            r_tens <= 4'd0;
            r_ones <= 4'd0;
            r_wrap <= 1'b0;
        end else if (w_step && bus.en) begin
            r_wrap <= 1'b0;
            if (bus.up_dn) begin
                if (w_at_max) begin
                    r_tens <= 4'd0;
                    r_ones <= 4'd0;
                    r_wrap <= 1'b1;
                end else if (r_ones == 4'd9) begin
                    r_ones <= 4'd0;
                    r_tens <= r_tens + 4'd1;
                end else begin
                    r_ones <= r_ones + 4'd1;
                end
            end else begin
                if (w_at_zero) begin
                    r_tens <= MAX_TENS;
                    r_ones <= MAX_ONES;
                    r_wrap <= 1'b1;
                end else if (r_ones == 4'd0) begin
                    r_ones <= 4'd9;
                    r_tens <= r_tens - 4'd1;
                end else begin
                    r_ones <= r_ones - 4'd1;
                end
            end
        end else begin
            r_wrap <= 1'b0;
        end
    end

    // r_dig_sel: 0 = ones digit, 1 = tens digit; each held for SCAN_DIV clocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scan_cnt <= '0;
            r_dig_sel  <= 1'b0;
        end else if (r_scan_cnt == SCAN_LAST) begin
            r_scan_cnt <= '0;
            r_dig_sel  <= ~r_dig_sel;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    always_comb begin
        w_digit  = r_ones;
        w_an_hi  = 2'b01;
        if (r_dig_sel) begin
            w_digit = r_tens;
            w_an_hi = 2'b10;
        end
        w_seg_hi = seg7(w_digit);
    end

    assign bus.bcd_tens = r_tens;
    assign bus.bcd_ones = r_ones;
    assign bus.wrap     = r_wrap;
    assign bus.seg      = w_seg_hi ^ {7{SEG_ACTIVE_LOW}};
    assign bus.an       = w_an_hi ^ {2{SEG_ACTIVE_LOW}};
endmodule

// File: tb/tb_tick_bcd_counter.sv
// Directed bench for tick_bcd_counter: two instances (MAX_COUNT 59 and 12, SCAN_DIV 4, active-low pins).
module tb_tick_bcd_counter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    tick_bcd_counter_if if_a ();
    tick_bcd_counter_if if_b ();

    tick_bcd_counter #(.MAX_COUNT(59), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a.slave)
    );

    tick_bcd_counter #(.MAX_COUNT(12), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] count_of(input int sel);
        if (sel == 0) return {if_a.bcd_tens, if_a.bcd_ones};
        return {if_b.bcd_tens, if_b.bcd_ones};
    endfunction

    function automatic logic wrap_of(input int sel);
        if (sel == 0) return if_a.wrap;
        return if_b.wrap;
    endfunction

    task automatic set_tick(input int sel, input logic v);
        if (sel == 0) if_a.tick_in = v;
        else          if_b.tick_in = v;
    endtask

    // One tick pulse: hi clocks high, 6 clocks low; counts wrap-high samples seen meanwhile.
    task automatic pulse(input int sel, input int hi, output int wraps);
        wraps = 0;
        set_tick(sel, 1'b1);
        repeat (hi) begin
            @(negedge clk);
            if (wrap_of(sel)) wraps++;
        end
        set_tick(sel, 1'b0);
        repeat (6) begin
            @(negedge clk);
            if (wrap_of(sel)) wraps++;
        end
    endtask

    task automatic ticks(input int sel, input int n, output int wraps);
        int w;
        wraps = 0;
        for (int i = 0; i < n; i++) begin
            pulse(sel, 4, w);
            wraps += w;
        end
    endtask

    task automatic clear_a();
        @(negedge clk);
        if_a.clr = 1'b1;
        @(negedge clk);
        if_a.clr = 1'b0;
    endtask

    initial begin
        int w;
        logic [1:0] prev_an;
        int run;
        int transitions;

        if_a.tick_in = 1'b1;
        if_a.en      = 1'b1;
        if_a.up_dn   = 1'b1;
        if_a.clr     = 1'b0;
        if_b.tick_in = 1'b0;
        if_b.en      = 1'b1;
        if_b.up_dn   = 1'b1;
        if_b.clr     = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_count", {24'd0, count_of(0)}, 32'h00);
        check("reset_wrap", {31'd0, if_a.wrap}, 32'd0);
        check("reset_an", {30'd0, if_a.an}, 32'h2);
        check("reset_seg", {25'd0, if_a.seg}, 32'h40);

        // Release reset with tick already high: no step may result.
        rst = 1'b0;
        w = 0;
        repeat (10) begin
            @(negedge clk);
            if (if_a.wrap) w++;
        end
        check("tick_high_at_reset_count", {24'd0, count_of(0)}, 32'h00);
        check("tick_high_at_reset_wrap", w, 0);

        if_a.tick_in = 1'b0;
        repeat (4) @(negedge clk);
        if_a.tick_in = 1'b1;
        repeat (3) @(negedge clk);
        check("first_rise_latency", {24'd0, count_of(0)}, 32'h01);
        repeat (4) @(negedge clk);
        if_a.tick_in = 1'b0;
        repeat (6) @(negedge clk);

        clear_a();
        check("clr_to_zero", {24'd0, count_of(0)}, 32'h00);
        ticks(0, 9, w);
        check("up_to_09", {24'd0, count_of(0)}, 32'h09);
        ticks(0, 1, w);
        check("up_carry_10", {24'd0, count_of(0)}, 32'h10);
        pulse(0, 1000, w);
        check("long_pulse_single_step", {24'd0, count_of(0)}, 32'h11);

        ticks(0, 48, w);
        check("up_to_59", {24'd0, count_of(0)}, 32'h59);
        check("no_wrap_below_max", w, 0);
        ticks(0, 1, w);
        check("up_wrap_count", {24'd0, count_of(0)}, 32'h00);
        check("up_wrap_pulse_len", w, 1);

        if_a.up_dn = 1'b0;
        ticks(0, 1, w);
        check("down_wrap_count", {24'd0, count_of(0)}, 32'h59);
        check("down_wrap_pulse_len", w, 1);

        clear_a();
        if_a.up_dn = 1'b1;
        ticks(0, 10, w);
        if_a.up_dn = 1'b0;
        ticks(0, 1, w);
        check("down_borrow_09", {24'd0, count_of(0)}, 32'h09);
        check("down_borrow_no_wrap", w, 0);

        if_a.en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if_a.up_dn = (i % 2 == 0);
            pulse(0, 4, w);
        end
        check("en_low_hold", {24'd0, count_of(0)}, 32'h09);
        if_a.en    = 1'b1;
        if_a.up_dn = 1'b1;

        // clr lands exactly on the step cycle (two edges after tick seen high).
        @(negedge clk);
        if_a.tick_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        if_a.clr = 1'b1;
        @(negedge clk);
        if_a.clr = 1'b0;
        check("clr_beats_step_count", {24'd0, count_of(0)}, 32'h00);
        check("clr_beats_step_wrap", {31'd0, if_a.wrap}, 32'd0);
        repeat (4) @(negedge clk);
        if_a.tick_in = 1'b0;
        repeat (6) @(negedge clk);
        check("clr_step_dropped", {24'd0, count_of(0)}, 32'h00);

        // Second instance wraps at 12 both ways.
        ticks(1, 12, w);
        check("b_up_to_12", {24'd0, count_of(1)}, 32'h12);
        check("b_no_early_wrap", w, 0);
        ticks(1, 1, w);
        check("b_up_wrap_count", {24'd0, count_of(1)}, 32'h00);
        check("b_up_wrap_pulse", w, 1);
        if_b.up_dn = 1'b0;
        ticks(1, 1, w);
        check("b_down_wrap_count", {24'd0, count_of(1)}, 32'h12);
        check("b_down_wrap_pulse", w, 1);

        // Display scan with count 37.
        ticks(0, 37, w);
        check("display_count", {24'd0, count_of(0)}, 32'h37);
        prev_an = if_a.an;
        run = 0;
        transitions = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            check("an_one_hot", {31'd0, (if_a.an == 2'b10) || (if_a.an == 2'b01)}, 32'd1);
            if (if_a.an == 2'b10) check("seg_ones_7", {25'd0, if_a.seg}, 32'h78);
            else                  check("seg_tens_3", {25'd0, if_a.seg}, 32'h30);
            if (if_a.an != prev_an) begin
                if (transitions > 0) check("scan_slot_len", run, 4);
                transitions++;
                run = 1;
            end else begin
                run++;
            end
            prev_an = if_a.an;
        end
        check("scan_toggled", {31'd0, transitions >= 5}, 32'd1);

        // Asynchronous reset mid-operation takes effect before the next clock edge.
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("async_reset_count", {24'd0, count_of(0)}, 32'h00);
        check("async_reset_an", {30'd0, if_a.an}, 32'h2);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tick_bcd_counter.md
Name: tick_bcd_counter

Overview:
- Consumes the slow square-wave tick from the DIP-selectable frequency divider and counts its rising edges as a two-digit BCD up/down counter.
- Drives a 2-digit multiplexed seven-segment display.
- Runs entirely on the 50 MHz system clock; the divider output is treated as an asynchronous input and synchronised internally.

Parameters:
- MAX_COUNT, 59, terminal decimal value of the counter (legal 1..99); the count wraps MAX_COUNT<->0.
- SCAN_DIV, 50000, system clocks per display digit slot (legal >=2).
- SEG_ACTIVE_LOW, 1, 1 = seg and an outputs active-low (common-anode); 0 = active-high.

Ports:
- clk  input  1  50 MHz system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- tick_in  input  1  divider output; async square wave, any duty cycle, period >> 4 clk.
- en  input  1  count enable; sampled on the step cycle.
- up_dn  input  1  1 = count up, 0 = count down.
- clr  input  1  synchronous clear of the count.
- bcd_tens  output  4  tens digit, BCD.
- bcd_ones  output  4  ones digit, BCD.
- wrap  output  1  one-clk pulse when the count wraps.
- seg  output  7  segments {g,f,e,d,c,b,a} for the active digit.
- an  output  2  digit enables; an[0] = ones, an[1] = tens.

Behaviour:
- Reset values:
  - bcd_tens = 0, bcd_ones = 0, wrap = 0.
  - Scan counter = 0, digit select = ones.
  - All three tick sync/edge flops = 1. This prevents a spurious step if tick_in is high at reset release.
- Synchroniser: s1 <= tick_in, s2 <= s1, s3 <= s2. step = s2 & ~s3.
  - step is a single-clk pulse per tick_in rising edge.
  - step is asserted on the 3rd clk edge after the first clk edge that samples tick_in high (2-3 clk latency).
  - Falling edges are ignored.
- Count update, evaluated each clk in priority order:
  1. clr = 1: count <= 00, wrap <= 0, regardless of step/en.
  2. step & en & up_dn:
     - count == MAX_COUNT: count <= 00, wrap <= 1.
     - bcd_ones == 9: ones <= 0, tens <= tens + 1.
     - otherwise ones <= ones + 1.
  3. step & en & ~up_dn:
     - count == 00: count <= MAX_COUNT, wrap <= 1.
     - bcd_ones == 0: ones <= 9, tens <= tens - 1.
     - otherwise ones <= ones - 1.
  4. Otherwise hold; wrap <= 0.
- Step-edge rules:
  - A step arriving with en = 0 is discarded, not queued.
  - up_dn is sampled only on the step cycle.
- Out-of-range values: digits never hold values > 9. MAX_COUNT is split at elaboration into tens = MAX_COUNT/10 and ones = MAX_COUNT%10.
- Display scan:
  - The scan counter counts 0..SCAN_DIV-1 and wraps.
  - On wrap, digit select toggles (ones -> tens -> ones ...), giving SCAN_DIV clk per digit.
  - an enables exactly one digit at all times, never both and never neither.
  - seg shows the selected digit's current value (combinational from the registered digit and select). It is valid in the same cycle the count changes.
- Seven-segment decode:
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07, 8:7F, 9:6F (active-high, bit0 = a).
  - Any other code decodes to blank 00.
  - When SEG_ACTIVE_LOW = 1, seg and an are inverted at the pins.
- No leading-zero blanking.
- Reset mid-operation clears the count and scan immediately (async). Any in-flight step is dropped.

Test Plan:
- Reset/edge safety: hold tick_in = 1 through reset, release, wait 10 clk -> count stays 00, wrap never asserted. Then drop tick_in and raise it -> count 01 within 3 clk of the rise.
- Up-count with BCD carry: en = 1, up_dn = 1, 10 ticks from 00 -> 09 then 10 (tens = 1, ones = 0). One step per tick; a 1000-clk-long high pulse yields exactly one increment.
- Up wrap: MAX_COUNT = 59, preload via ticks to 59, one more tick -> 00 and wrap high for exactly 1 clk. Repeat with MAX_COUNT = 12: 12 -> 00.
- Down wrap and borrow: up_dn = 0 from 10, one tick -> 09; from 00, one tick -> 59 with a 1-clk wrap pulse.
- Enable/clear priority:
  - en = 0 with 5 ticks -> count unchanged.
  - clr asserted on the same clk as step -> count 00, wrap 0.
- Display: SCAN_DIV = 4, SEG_ACTIVE_LOW = 1, count 37.
  - Expected per slot: an = 2'b10 / seg = ~7'h07 (ones = 7) for 4 clk, then an = 2'b01 / seg = ~7'h4F (tens = 3) for 4 clk, repeating.
  - an is never 2'b00 or 2'b11.
